// File: rtl/vector_load_sequencer.sv
// Multi-beat sequencer for vector-register loads: stalls the pipeline, issues one
// data-memory read per element and writes each returned word into the target register.
module vector_load_sequencer #(
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned IDXW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_wvr,
    input  logic [1:0]      vl,
    input  logic [AW-1:0]   base_addr,
    output logic            stall_out,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    input  logic            mem_ready,
    input  logic [DW-1:0]   mem_rdata,
    output logic            wvr_we,
    output logic            svr_we,
    output logic [IDXW-1:0] vr_idx,
    output logic [DW-1:0]   vr_wdata,
    output logic            done,
    output logic            err
);

    // One extra bit so the element count itself (up to 2**IDXW) is representable.
    localparam int unsigned CW = IDXW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [CW-1:0] n_q, n_d;
    logic [CW-1:0] issue_cnt_q, issue_cnt_d;
    logic [CW-1:0] ret_cnt_q, ret_cnt_d;
    logic          tgt_q, tgt_d;
    logic          pend_q, pend_d;

    logic legal;
    logic launch;
    logic final_ret;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        tgt_d       = tgt_q;

        legal     = (vl != 2'b11);
        launch    = (state_q == StIdle) && start && legal;
        final_ret = pend_q && (ret_cnt_q == n_q - CW'(1));

        mem_req   = (state_q == StIssue);
        mem_addr  = mem_req ? base_q + (AW'(issue_cnt_q) << 2) : '0;
        wvr_we    = pend_q & tgt_q;
        svr_we    = pend_q & ~tgt_q;
        vr_idx    = pend_q ? ret_cnt_q[IDXW-1:0] : '0;
        vr_wdata  = pend_q ? mem_rdata : '0;
        done      = final_ret;
        err       = (state_q == StIdle) && start && !legal;
        stall_out = launch | ((state_q != StIdle) && !final_ret);

        // Read data comes back exactly one cycle after each accepted request.
        pend_d = mem_req & mem_ready;
        if (pend_q) begin
            ret_cnt_d = ret_cnt_q + CW'(1);
        end

        case (state_q)
            StIdle: begin
                if (launch) begin
                    state_d     = StIssue;
                    base_d      = base_addr;
                    n_d         = CW'(4) << vl;
                    tgt_d       = is_wvr;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end
            StIssue: begin
                if (mem_ready) begin
                    issue_cnt_d = issue_cnt_q + CW'(1);
                    if (issue_cnt_q == n_q - CW'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (final_ret) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            base_q      <= '0;
            n_q         <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            tgt_q       <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            n_q         <= n_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            tgt_q       <= tgt_d;
            pend_q      <= pend_d;
        end
    end

endmodule

// File: tb/tb_vector_load_sequencer.sv
// Randomized bench for vector_load_sequencer: a transaction-level model predicts every
// output on every cycle; directed scenarios add literal expectations.
module tb_vector_load_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_wvr;
    logic [1:0]  vl;
    logic [31:0] base_addr;
    logic        stall_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        wvr_we;
    logic        svr_we;
    logic [3:0]  vr_idx;
    logic [31:0] vr_wdata;
    logic        done;
    logic        err;

    vector_load_sequencer #(.AW(32), .DW(32), .IDXW(4)) dut (
        .clk(clk), .rst(rst), .start(start), .is_wvr(is_wvr), .vl(vl),
        .base_addr(base_addr), .stall_out(stall_out), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .wvr_we(wvr_we), .svr_we(svr_we), .vr_idx(vr_idx), .vr_wdata(vr_wdata),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int n_wvr = 0;
    int n_svr = 0;
    int n_done = 0;
    bit chk_en = 0;

    // Memory responder state
    bit          rd_pending = 0;
    logic [31:0] rd_addr = '0;

    // Transaction-level model of the operation in flight
    bit          m_busy = 0;
    int          m_n = 0;
    logic [31:0] m_base = '0;
    bit          m_wvr = 0;
    int          m_acc = 0;
    int          m_ret = 0;
    bit          m_pend = 0;
    logic [31:0] m_pend_addr = '0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(negedge clk) begin
        bit          ret, fin, exp_req, exp_err, exp_stall, lg;
        logic [31:0] exp_addr;
        lg        = (vl != 2'd3);
        ret       = m_pend;
        fin       = ret && (m_ret == m_n - 1);
        exp_req   = m_busy && (m_acc < m_n);
        exp_addr  = exp_req ? m_base + 32'(m_acc) * 32'd4 : 32'd0;
        exp_err   = !m_busy && start && !lg;
        exp_stall = (!m_busy && start && lg) || (m_busy && !fin);
        if (chk_en) begin
            chk("stall_out", {63'b0, stall_out}, {63'b0, exp_stall});
            chk("mem_req",   {63'b0, mem_req},   {63'b0, exp_req});
            chk("mem_addr",  {32'b0, mem_addr},  {32'b0, exp_addr});
            chk("wvr_we",    {63'b0, wvr_we},    {63'b0, ret && m_wvr});
            chk("svr_we",    {63'b0, svr_we},    {63'b0, ret && !m_wvr});
            chk("vr_idx",    {60'b0, vr_idx},    ret ? 64'(m_ret) : 64'd0);
            chk("vr_wdata",  {32'b0, vr_wdata},  ret ? {32'b0, memf(m_pend_addr)} : 64'd0);
            chk("done",      {63'b0, done},      {63'b0, fin});
            chk("err",       {63'b0, err},       {63'b0, exp_err});
            if (wvr_we === 1'b1) n_wvr++;
            if (svr_we === 1'b1) n_svr++;
            if (done === 1'b1) n_done++;
        end
        rd_pending = (mem_req === 1'b1) && mem_ready;
        rd_addr    = mem_addr;
        if (rst) begin
            m_busy = 0;
            m_pend = 0;
            rd_pending = 0;
        end else begin
            if (ret) m_ret++;
            m_pend      = exp_req && mem_ready;
            m_pend_addr = exp_addr;
            if (exp_req && mem_ready) m_acc++;
            if (fin) begin
                m_busy = 0;
            end else if (!m_busy && start && lg) begin
                m_busy = 1;
                m_n    = 4 << vl;
                m_base = base_addr;
                m_wvr  = is_wvr;
                m_acc  = 0;
                m_ret  = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = rd_pending ? memf(rd_addr) : $urandom();
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 400 && m_busy; i++) tick();
        if (m_busy) chk({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic launch(input logic [1:0] v, input logic w, input logic [31:0] b);
        start = 1'b1;
        vl = v;
        is_wvr = w;
        base_addr = b;
    endtask

    logic [31:0] exp_a [4];
    int          wr_before;

    initial begin
        rst = 1'b1; start = 1'b0; is_wvr = 1'b0; vl = 2'd0; base_addr = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        tick();
        chk_en = 1;
        tick();
        @(negedge clk);
        chk("rst_stall", {63'b0, stall_out}, 64'd0);
        chk("rst_addr", {32'b0, mem_addr}, 64'd0);
        chk("rst_idx", {60'b0, vr_idx}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // vl=00 to the weight register, always ready
        mem_ready = 1'b1;
        n_svr = 0;
        launch(2'd0, 1'b1, 32'h100);
        @(negedge clk);
        chk("t1_stall_c0", {63'b0, stall_out}, 64'd1);
        chk("t1_req_c0", {63'b0, mem_req}, 64'd0);
        tick();
        start = 1'b0;
        exp_a[0] = 32'h100; exp_a[1] = 32'h104; exp_a[2] = 32'h108; exp_a[3] = 32'h10C;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_addr", {32'b0, mem_addr}, {32'b0, exp_a[k]});
            chk("t1_stall", {63'b0, stall_out}, 64'd1);
            tick();
        end
        @(negedge clk);
        chk("t1_done", {63'b0, done}, 64'd1);
        chk("t1_idx3", {60'b0, vr_idx}, 64'd3);
        chk("t1_data3", {32'b0, vr_wdata}, {32'b0, memf(32'h10C)});
        chk("t1_stall_c5", {63'b0, stall_out}, 64'd0);
        tick();
        chk("t1_no_svr", 64'(n_svr), 64'd0);

        // vl=10 to the other register, ready low every third cycle
        n_svr = 0; n_done = 0;
        launch(2'd2, 1'b0, 32'h2000);
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && m_busy; i++) begin
            mem_ready = (i % 3) != 2;
            tick();
        end
        chk("t2_svr_count", 64'(n_svr), 64'd16);
        chk("t2_done_count", 64'(n_done), 64'd1);

        // illegal vl
        mem_ready = 1'b1;
        launch(2'd3, 1'b1, 32'h40);
        @(negedge clk);
        chk("t3_err", {63'b0, err}, 64'd1);
        chk("t3_stall", {63'b0, stall_out}, 64'd0);
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("t3_err_after", {63'b0, err}, 64'd0);
        chk("t3_req_after", {63'b0, mem_req}, 64'd0);
        tick();

        // reset after two of eight returns
        launch(2'd1, 1'b1, 32'h300);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wr_before = n_wvr + n_svr;
        @(negedge clk);
        chk("t4_stall", {63'b0, stall_out}, 64'd0);
        chk("t4_req", {63'b0, mem_req}, 64'd0);
        chk("t4_we", {62'b0, wvr_we, svr_we}, 64'd0);
        tick();
        tick();
        chk("t4_no_writes", 64'(n_wvr + n_svr), 64'(wr_before));
        launch(2'd0, 1'b0, 32'h400);
        tick();
        start = 1'b0;
        wait_idle("t4");

        // back-to-back: start held through the first op's done cycle
        n_done = 0; n_wvr = 0; n_svr = 0;
        launch(2'd0, 1'b1, 32'h500);
        for (int i = 0; i < 50 && n_done == 0; i++) tick();
        base_addr = 32'h600;
        tick();
        start = 1'b0;
        wait_idle("t5");
        tick();
        chk("t5_done_count", 64'(n_done), 64'd2);
        chk("t5_write_count", 64'(n_wvr), 64'd8);

        // address wrap
        launch(2'd0, 1'b0, 32'hFFFF_FFF8);
        tick();
        start = 1'b0;
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t6_addr", {32'b0, mem_addr}, {32'b0, exp_a[k]});
            tick();
        end
        wait_idle("t6");

        // randomized operations
        for (int op = 0; op < 40; op++) begin
            launch(2'($urandom_range(0, 3)), 1'($urandom()), $urandom());
            mem_ready = ($urandom_range(0, 3) != 0);
            tick();
            start = 1'b0;
            for (int i = 0; i < 400 && m_busy; i++) begin
                mem_ready = ($urandom_range(0, 3) != 0);
                start = ($urandom_range(0, 5) == 0);
                vl = 2'($urandom_range(0, 3));
                is_wvr = 1'($urandom());
                base_addr = $urandom();
                rst = (op % 7 == 3) && (i == 4);
                if (rst) start = 1'b0;
                tick();
            end
            rst = 1'b0;
            start = 1'b0;
            wait_idle("rand");
        end
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
